// File: rtl/uart_tx_sched_if.sv
// uart_tx_sched_if
// Bundles the register-file side and transmitter side signals of the UART
// transmit scheduler so they travel as one port.
//   master : the register file / transmitter environment (drives wr_en,
//            wr_data, enable, dvsr, tx_done, clr_ovf; observes everything else)
//   slave  : the scheduler itself (drives s_tick, tx_start, tx_data, busy,
//            full, empty, count, overflow)
// DEPTH is the FIFO depth (power of two, >= 2) and DW the byte width.
interface uart_tx_sched_if #(
   parameter int DEPTH = 4,
   parameter int DW    = 8
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic          wr_en;
   logic [DW-1:0] wr_data;
   logic          enable;
   logic [10:0]   dvsr;
   logic          tx_done;
   logic          clr_ovf;

   logic          s_tick;
   logic          tx_start;
   logic [DW-1:0] tx_data;
   logic          busy;
   logic          full;
   logic          empty;
   logic [CW-1:0] count;
   logic          overflow;

   modport master (
      output wr_en, wr_data, enable, dvsr, tx_done, clr_ovf,
      input  s_tick, tx_start, tx_data, busy, full, empty, count, overflow
   );

   modport slave (
      input  wr_en, wr_data, enable, dvsr, tx_done, clr_ovf,
      output s_tick, tx_start, tx_data, busy, full, empty, count, overflow
   );
endinterface

// File: rtl/uart_tx_sched.sv
// uart_tx_sched
// Transmit scheduler for the memory-mapped UART. Queues CPU-written bytes in
// a small circular FIFO, produces the baud tick from the programmed divisor
// and hands bytes to the transmitter one at a time with a start/done pulse
// handshake.
// Ports:
//   clk    : system clock, all state changes on the rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : uart_tx_sched_if.slave
//            inputs  wr_en, wr_data, enable, dvsr, tx_done, clr_ovf
//            outputs s_tick, tx_start, tx_data, busy, full, empty, count,
//                    overflow
module uart_tx_sched #(
   parameter int DEPTH = 4,
   parameter int DW    = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   uart_tx_sched_if.slave bus
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      BUSY  = 2'd2
   } state_t;

   state_t        state_q;
   state_t        state_d;

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [CW-1:0] count_q;

   logic          overflow_q;
   logic          tx_start_q;
   logic [DW-1:0] tx_data_q;

   logic [10:0]   baud_q;
   logic [10:0]   baud_d;
   logic          s_tick_q;

   logic          full_w;
   logic          empty_w;
   logic          push_ok;
   logic          push_drop;
   logic          pop;

   // FIFO status decodes straight from the registered occupancy. A push is
   // judged against the count before the edge, so a push arriving while full
   // is dropped even if a pop frees a slot at that same edge.
   always_comb begin
      full_w    = (count_q == CW'(DEPTH));
      empty_w   = (count_q == '0);
      push_ok   = bus.wr_en && !full_w;
      push_drop = bus.wr_en && full_w;
   end

   // Next-state logic for the byte sequencer. The pop is tied to the
   // IDLE->START transition so the head byte is captured exactly when the
   // transmitter is told to start. tx_done only matters in BUSY, and a
   // dropped enable never aborts a byte already started.
   always_comb begin
      state_d = state_q;
      pop     = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.enable && !empty_w) begin
               state_d = START;
               pop     = 1'b1;
            end
         end
         START: begin
            state_d = BUSY;
         end
         BUSY: begin
            if (bus.tx_done) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State register plus the registered start pulse, which is high for
   // exactly the one cycle spent in START.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         tx_start_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         tx_start_q <= (state_d == START);
      end
   end

   // Storage array. It carries no reset: after reset the pointers and count
   // say the FIFO is empty, so whatever the array still holds is never read.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr_q] <= bus.wr_data;
      end
   end

   // Pointers and occupancy. Pointers are AW bits and wrap naturally because
   // DEPTH is a power of two; the count is kept separately so full and empty
   // are unambiguous. A simultaneous push and pop leaves the count alone.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         case ({push_ok, pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Byte handed to the transmitter. Loaded only on the pop, so it holds
   // steady through START and BUSY and on until the next byte starts.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_data_q <= '0;
      end else if (pop) begin
         tx_data_q <= mem[rd_ptr_q];
      end
   end

   // Sticky overflow flag. A dropped push in the same cycle as a clear keeps
   // the flag set so software never loses the evidence of a lost byte.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow_q <= 1'b0;
      end else if (push_drop) begin
         overflow_q <= 1'b1;
      end else if (bus.clr_ovf) begin
         overflow_q <= 1'b0;
      end
   end

   // Baud counter counts 0..dvsr and wraps. If dvsr is lowered below the
   // current count the counter simply runs on through 2^11 back to zero;
   // software is expected to change the divisor only while idle.
   always_comb begin
      if (baud_q == bus.dvsr) begin
         baud_d = '0;
      end else begin
         baud_d = baud_q + 11'd1;
      end
   end

   // Counter register and registered tick. The tick is computed from the
   // next count so that it is high in the same cycle the counter sits at
   // dvsr; with dvsr==0 it stays high continuously. Runs regardless of
   // enable so the transmitter always has a bit clock.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         baud_q   <= '0;
         s_tick_q <= 1'b0;
      end else begin
         baud_q   <= baud_d;
         s_tick_q <= (baud_d == bus.dvsr);
      end
   end

   // Output drive. busy, full and empty are plain decodes of registered
   // state; everything else comes straight from a flop.
   assign bus.s_tick   = s_tick_q;
   assign bus.tx_start = tx_start_q;
   assign bus.tx_data  = tx_data_q;
   assign bus.busy     = (state_q != IDLE);
   assign bus.full     = full_w;
   assign bus.empty    = empty_w;
   assign bus.count    = count_q;
   assign bus.overflow = overflow_q;

endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Transmit scheduler for the memory-mapped UART: buffers bytes written by the CPU in a small FIFO, generates the baud-rate tick from the programmed divisor, and sequences the transmitter one byte at a time using a start-pulse/done-pulse handshake. It sits between the UART register file (data, divisor, enable) and the UART transmitter shift logic. It replaces the single-byte "full" flag with FIFO status.

## Interface
- DEPTH, 4: FIFO entries; power of two, at least 2.
- DW, 8: data width per entry.

- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- wr_en  in  1  CPU push strobe; one byte per cycle while high.
- wr_data  in  DW  byte to queue.
- enable  in  1  scheduler enable (register-file start bit).
- dvsr  in  11  baud divisor; tick period is dvsr+1 cycles.
- tx_done  in  1  one-cycle pulse from the transmitter at the end of the stop bit.
- clr_ovf  in  1  clears the sticky overflow flag.
- s_tick  out  1  one-cycle baud tick to the transmitter.
- tx_start  out  1  one-cycle start pulse to the transmitter.
- tx_data  out  DW  byte being transmitted; registered.
- busy  out  1  high in START and BUSY states.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- count  out  $clog2(DEPTH)+1  current FIFO occupancy.
- overflow  out  1  sticky: a push was dropped.

## Operation
- FIFO: circular buffer with rd/wr pointers of $clog2(DEPTH) bits that wrap modulo DEPTH. Count is tracked separately.
- A push with `full==1` is dropped and sets `overflow`. The full check uses the pre-edge count, so a push in the same cycle as a pop while full is still dropped.
- Push and pop in the same cycle with `0<count<DEPTH`: both happen and count is unchanged.
- `clr_ovf` clears `overflow`. If a dropped push occurs in the same cycle, the set wins.
- Baud counter: 11-bit, counts 0..dvsr and wraps to 0.
  - `s_tick` is high in the cycle the counter equals dvsr.
  - `dvsr==0` gives a tick every cycle.
  - If dvsr is changed to a value below the current count, the counter wraps through 2^11. Software changes dvsr only while idle.
  - The counter runs regardless of `enable`.
- FSM states:
  - IDLE → START when `enable && !empty`.
  - START → BUSY unconditionally.
  - BUSY → IDLE on `tx_done`.
- Entering START pops the FIFO head into `tx_data`. `tx_start` is high exactly while in START.
- `tx_done` is ignored in IDLE and START.
- Deasserting `enable` in START or BUSY does not abort the transfer: the current byte completes, then the FSM stays in IDLE.

## Timing
- Reset values: state IDLE, pointers 0, `count=0`, `empty=1`, `full=0`, `overflow=0`, `tx_start=0`, `tx_data=0`, `busy=0`, baud counter 0, `s_tick=0`.
- Reset asserted mid-transfer returns everything to the reset values immediately and discards the FIFO contents.
- A push at edge N is reflected in `count`, `empty` and `full` after edge N.
- Minimum latency from a push into an empty FIFO with `enable=1`:
  - edge N: byte written.
  - edge N+1: FSM enters START, `tx_data` loaded, `tx_start=1`.
  - edge N+2: BUSY.
- `tx_data` stays stable from START entry until the next START entry.
- After `tx_done` at edge M (BUSY→IDLE), the next START can occur at edge M+1. The minimum inter-byte gap is 1 idle cycle.
- All outputs are registered except `full`, `empty` and `busy`, which decode directly from registered state.

## Test plan
- Reset, then dvsr=3: `s_tick` pulses every 4th cycle. With dvsr=0, `s_tick` stays high continuously.
- enable=1; push 0xA5 into an empty FIFO:
  - `tx_start` pulses 1 cycle later with `tx_data=0xA5`, then `busy=1`.
  - `tx_done` → idle, `empty=1`.
- enable=0; push 0x11, 0x22, 0x33, 0x44 (DEPTH=4):
  - `full=1`.
  - Push 0x55 → dropped, `overflow=1`.
  - enable=1 → bytes 0x11..0x44 go out in order, each after the prior `tx_done`. 0x55 is never sent.
- Simultaneous push and START pop at count=2: count stays 2 and the pointers wrap correctly across 6+ bytes.
- Deassert enable during BUSY with 2 bytes queued: the current byte finishes on `tx_done`, no further `tx_start`, count=2 is held. Re-enabling resumes.
- Assert rst_n=0 during BUSY: outputs return to the reset values asynchronously, the FIFO reads empty, and a late `tx_done` after reset has no effect.
